// File: rtl/elixirchip_es1_spu_op_acc.sv
// Pipelined accumulator for the ES1 SPU datapath.
// Adds each valid input word into a running sum (optionally restarted from
// CLEAR_DATA) and presents the new sum and its carry after LATENCY cke edges.
// Outputs hold between valid results so the downstream op_reg stage sees
// stable data.
module elixirchip_es1_spu_op_acc #(
   parameter int unsigned LATENCY    = 1,
   parameter int unsigned DATA_BITS  = 8,
   parameter type         data_t     = logic [DATA_BITS-1:0],
   parameter data_t       CLEAR_DATA = '0,
   parameter string       DEVICE     = "RTL",
   parameter string       SIMULATION = "false",
   parameter string       DEBUG      = "false"
) (
   input  logic  clk,
   input  logic  reset_n,
   input  logic  cke,
   input  data_t s_data,
   input  logic  s_clear,
   input  logic  s_valid,
   output data_t m_data,
   output logic  m_carry,
   output logic  m_valid
);

   localparam int unsigned SUM_BITS = DATA_BITS + 1;

   // Elaboration-time parameter sanity checks
   if (LATENCY < 1 || LATENCY > 8) begin : g_bad_latency
      $error("elixirchip_es1_spu_op_acc: LATENCY must be in 1..8");
   end
   if ($bits(data_t) != DATA_BITS) begin : g_bad_data_t
      $error("elixirchip_es1_spu_op_acc: data_t width must equal DATA_BITS");
   end
   if (DEVICE == "") begin : g_bad_device
      $error("elixirchip_es1_spu_op_acc: DEVICE must be named");
   end
   if ((SIMULATION != "true" && SIMULATION != "false") ||
       (DEBUG != "true" && DEBUG != "false")) begin : g_bad_switch
      $error("elixirchip_es1_spu_op_acc: SIMULATION/DEBUG must be \"true\" or \"false\"");
   end

   // Running sum and per-stage payload; index 0 is stage 1
   data_t               acc;
   data_t               base_c;
   logic [SUM_BITS-1:0] sum_c;
   data_t               data_q  [LATENCY];
   logic [LATENCY-1:0]  carry_q;
   logic [LATENCY-1:0]  valid_q;

   // Stage-1 adder: base is either the running sum or the restart value
   always_comb begin
      base_c = acc;
      if (s_clear) begin
         base_c = CLEAR_DATA;
      end
      sum_c = SUM_BITS'(base_c) + SUM_BITS'(s_data);
   end

   // Running sum register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc <= CLEAR_DATA;
      end else if (cke) begin
         if (s_valid) begin
            acc <= data_t'(sum_c[DATA_BITS-1:0]);
         end else if (s_clear) begin
            acc <= CLEAR_DATA;
         end
      end
   end

   // Stage 1: payload loads only with a valid word so it holds otherwise
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q[0]  <= CLEAR_DATA;
         carry_q[0] <= 1'b0;
         valid_q[0] <= 1'b0;
      end else if (cke) begin
         valid_q[0] <= s_valid;
         if (s_valid) begin
            data_q[0]  <= data_t'(sum_c[DATA_BITS-1:0]);
            carry_q[0] <= sum_c[DATA_BITS];
         end
      end
   end

   // Stages 2..LATENCY: valid always shifts, payload moves only behind a valid
   for (genvar k = 1; k < LATENCY; k++) begin : g_stage
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            data_q[k]  <= CLEAR_DATA;
            carry_q[k] <= 1'b0;
            valid_q[k] <= 1'b0;
         end else if (cke) begin
            valid_q[k] <= valid_q[k-1];
            if (valid_q[k-1]) begin
               data_q[k]  <= data_q[k-1];
               carry_q[k] <= carry_q[k-1];
            end
         end
      end
   end

   // Outputs come straight from the last stage registers
   assign m_data  = data_q[LATENCY-1];
   assign m_carry = carry_q[LATENCY-1];
   assign m_valid = valid_q[LATENCY-1];

   // s_valid must be a known level whenever the block is clocked
   a_valid_known : assert property (@(posedge clk) disable iff (!reset_n)
      cke |-> !$isunknown(s_valid));

endmodule

// File: tb/tb_elixirchip_es1_spu_op_acc.sv
// Bench for elixirchip_es1_spu_op_acc: four instances (LATENCY/DATA_BITS of
// 1/8, 3/8, 2/32, 4/32) share one stimulus stream; a scoreboard predicts
// every result and its due cke-edge, and hand-written tables pin down the
// directed cases.
module tb_elixirchip_es1_spu_op_acc;

   localparam int NDUT = 4;
   localparam int LAT  [NDUT] = '{1, 3, 2, 4};
   localparam bit WIDE [NDUT] = '{1'b0, 1'b0, 1'b1, 1'b1};

   typedef struct {
      int unsigned dut;
      logic [31:0] data;
      logic        carry;
      int unsigned due;
   } exp_t;

   typedef struct {
      logic        cke;
      logic        valid;
      logic        clear;
      logic [7:0]  data;
      logic        exp_v;
      logic [7:0]  exp_d;
      logic        exp_c;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        cke;
   logic        s_valid;
   logic        s_clear;
   logic [31:0] s_data;

   logic [7:0]  m_data0, m_data1;
   logic [31:0] m_data2, m_data3;
   logic        m_carry0, m_carry1, m_carry2, m_carry3;
   logic        m_valid0, m_valid1, m_valid2, m_valid3;

   int          checks = 0;
   int          errors = 0;
   int unsigned edge_cnt = 0;
   logic [7:0]  acc8;
   logic [31:0] acc32;
   exp_t        exp_q [$];
   logic [31:0] last_d [NDUT];
   logic        last_c [NDUT];
   logic        last_v [NDUT];

   always #5 clk = ~clk;

   elixirchip_es1_spu_op_acc #(.LATENCY(1), .DATA_BITS(8)) u_dut_l1 (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(s_data[7:0]),
      .s_clear(s_clear), .s_valid(s_valid),
      .m_data(m_data0), .m_carry(m_carry0), .m_valid(m_valid0));

   elixirchip_es1_spu_op_acc #(.LATENCY(3), .DATA_BITS(8)) u_dut_l3 (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(s_data[7:0]),
      .s_clear(s_clear), .s_valid(s_valid),
      .m_data(m_data1), .m_carry(m_carry1), .m_valid(m_valid1));

   elixirchip_es1_spu_op_acc #(.LATENCY(2), .DATA_BITS(32)) u_dut_l2w (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(s_data),
      .s_clear(s_clear), .s_valid(s_valid),
      .m_data(m_data2), .m_carry(m_carry2), .m_valid(m_valid2));

   elixirchip_es1_spu_op_acc #(.LATENCY(4), .DATA_BITS(32)) u_dut_l4w (
      .clk(clk), .reset_n(reset_n), .cke(cke), .s_data(s_data),
      .s_clear(s_clear), .s_valid(s_valid),
      .m_data(m_data3), .m_carry(m_carry3), .m_valid(m_valid3));

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model state after reset: everything back to CLEAR_DATA (0)
   task automatic model_reset();
      acc8  = '0;
      acc32 = '0;
      exp_q.delete();
      for (int d = 0; d < NDUT; d++) begin
         last_d[d] = '0;
         last_c[d] = 1'b0;
         last_v[d] = 1'b0;
      end
   endtask

   // Reference accumulator, evaluated at each clock edge
   task automatic model_edge(input logic c, input logic v, input logic cl, input logic [31:0] d);
      logic [8:0]  sum9;
      logic [32:0] sum33;
      exp_t        e;
      if (c) begin
         edge_cnt++;
         sum9  = {1'b0, (cl ? 8'h00 : acc8)} + {1'b0, d[7:0]};
         sum33 = {1'b0, (cl ? 32'h0 : acc32)} + {1'b0, d};
         if (v) begin
            acc8  = sum9[7:0];
            acc32 = sum33[31:0];
            for (int k = 0; k < NDUT; k++) begin
               e.dut = k;
               e.due = edge_cnt + LAT[k] - 1;
               if (WIDE[k]) begin
                  e.data  = sum33[31:0];
                  e.carry = sum33[32];
               end else begin
                  e.data  = {24'h0, sum9[7:0]};
                  e.carry = sum9[8];
               end
               exp_q.push_back(e);
            end
         end else if (cl) begin
            acc8  = '0;
            acc32 = '0;
         end
      end
   endtask

   // Compare one instance against the scoreboard; outputs hold otherwise
   task automatic check_dut(input int d, input logic [31:0] act_d, input logic act_c,
                            input logic act_v, input logic edge_en);
      int   hit;
      logic exp_v;
      hit   = -1;
      exp_v = last_v[d];
      if (edge_en) begin
         exp_v = 1'b0;
         for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].dut == d) begin
               hit = i;
               break;
            end
         end
         if (hit >= 0 && exp_q[hit].due <= edge_cnt) begin
            exp_v     = 1'b1;
            last_d[d] = exp_q[hit].data;
            last_c[d] = exp_q[hit].carry;
            exp_q.delete(hit);
         end
      end
      last_v[d] = exp_v;
      chk($sformatf("sb_valid[%0d]", d), {31'h0, act_v}, {31'h0, exp_v});
      chk($sformatf("sb_data[%0d]", d),  act_d, last_d[d]);
      chk($sformatf("sb_carry[%0d]", d), {31'h0, act_c}, {31'h0, last_c[d]});
   endtask

   task automatic step(input logic c, input logic v, input logic cl, input logic [31:0] d);
      @(negedge clk);
      cke     = c;
      s_valid = v;
      s_clear = cl;
      s_data  = d;
      @(posedge clk);
      if (reset_n) model_edge(c, v, cl, d);
      #1;
      check_dut(0, {24'h0, m_data0}, m_carry0, m_valid0, c);
      check_dut(1, {24'h0, m_data1}, m_carry1, m_valid1, c);
      check_dut(2, m_data2, m_carry2, m_valid2, c);
      check_dut(3, m_data3, m_carry3, m_valid3, c);
   endtask

   initial begin
      vec_t        tbl [$];
      logic        t4_cke [9] = '{1, 0, 1, 1, 1, 1, 1, 1, 1};
      logic        t4_v   [9] = '{1, 1, 0, 0, 1, 0, 0, 0, 0};
      logic [7:0]  t4_d   [9] = '{8'h05, 8'h09, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00, 8'h00};
      logic        t4_ev  [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
      logic [7:0]  t4_ed  [9] = '{8'h04, 8'h04, 8'h04, 8'h09, 8'h09, 8'h09, 8'h13, 8'h13, 8'h13};

      //            cke  v  clr  data    exp_v exp_d  exp_c   (LATENCY=1, 8 bit)
      tbl.push_back('{1, 1, 0, 8'h10, 1, 8'h10, 0});
      tbl.push_back('{1, 1, 0, 8'h20, 1, 8'h30, 0});
      tbl.push_back('{1, 1, 0, 8'h30, 1, 8'h60, 0});
      tbl.push_back('{1, 1, 0, 8'h90, 1, 8'hF0, 0});
      tbl.push_back('{1, 1, 0, 8'h20, 1, 8'h10, 1});
      tbl.push_back('{1, 1, 0, 8'h01, 1, 8'h11, 0});
      tbl.push_back('{1, 1, 0, 8'h44, 1, 8'h55, 0});
      tbl.push_back('{1, 0, 1, 8'h00, 0, 8'h55, 0});
      tbl.push_back('{1, 1, 0, 8'h03, 1, 8'h03, 0});
      tbl.push_back('{1, 0, 0, 8'h00, 0, 8'h03, 0});
      tbl.push_back('{1, 1, 1, 8'h07, 1, 8'h07, 0});
      tbl.push_back('{1, 1, 0, 8'h01, 1, 8'h08, 0});
      tbl.push_back('{0, 1, 1, 8'h50, 1, 8'h08, 0});
      tbl.push_back('{1, 0, 0, 8'h00, 0, 8'h08, 0});
      tbl.push_back('{1, 1, 0, 8'hFF, 1, 8'h07, 1});
      tbl.push_back('{1, 0, 0, 8'h00, 0, 8'h07, 1});
      tbl.push_back('{1, 1, 1, 8'hFF, 1, 8'hFF, 0});

      reset_n = 1'b0;
      cke     = 1'b0;
      s_valid = 1'b0;
      s_clear = 1'b0;
      s_data  = '0;
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_valid", {28'h0, m_valid0, m_valid1, m_valid2, m_valid3}, 32'h0);
      chk("rst_carry", {28'h0, m_carry0, m_carry1, m_carry2, m_carry3}, 32'h0);
      chk("rst_data8", {m_data0, m_data1, 16'h0}, 32'h0);
      chk("rst_data32", m_data2 | m_data3, 32'h0);
      reset_n = 1'b1;

      // Directed table on the LATENCY=1 instance, scoreboard on all
      foreach (tbl[i]) begin
         step(tbl[i].cke, tbl[i].valid, tbl[i].clear, {24'h0, tbl[i].data});
         chk($sformatf("tbl_valid[%0d]", i), {31'h0, m_valid0}, {31'h0, tbl[i].exp_v});
         chk($sformatf("tbl_data[%0d]", i),  {24'h0, m_data0}, {24'h0, tbl[i].exp_d});
         chk($sformatf("tbl_carry[%0d]", i), {31'h0, m_carry0}, {31'h0, tbl[i].exp_c});
      end

      // Async reset with results in flight clears outputs before any edge
      step(1, 1, 0, 32'h11);
      step(1, 1, 0, 32'h22);
      @(negedge clk);
      s_valid = 1'b0;
      s_clear = 1'b0;
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", {28'h0, m_valid0, m_valid1, m_valid2, m_valid3}, 32'h0);
      chk("arst_carry", {28'h0, m_carry0, m_carry1, m_carry2, m_carry3}, 32'h0);
      chk("arst_data8", {m_data0, m_data1, 16'h0}, 32'h0);
      chk("arst_data32", m_data2 | m_data3, 32'h0);
      model_reset();
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      step(1, 1, 0, 32'h04);
      chk("post_rst_data", {24'h0, m_data0}, 32'h04);
      repeat (4) step(1, 0, 0, 32'h0);

      // LATENCY=3 timing with cke gaps: results land 2 cke-edges after input
      for (int i = 0; i < 9; i++) begin
         step(t4_cke[i], t4_v[i], 1'b0, {24'h0, t4_d[i]});
         chk($sformatf("lat3_valid[%0d]", i), {31'h0, m_valid1}, {31'h0, t4_ev[i]});
         chk($sformatf("lat3_data[%0d]", i),  {24'h0, m_data1}, {24'h0, t4_ed[i]});
      end

      // Random stimulus against the scoreboard
      for (int i = 0; i < 600; i++) begin
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), $urandom());
      end
      repeat (6) step(1, 0, 0, 32'h0);
      chk("sb_drain", 32'(exp_q.size()), 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
